// File: rtl/tdef_pkg.sv
// rtl/tdef_pkg.sv - clock bundle and three-phase sample stream types
package tdef_pkg;
  import tdef_prm::*;

  typedef struct packed {
    logic clk;
    logic rstn;
    logic ce;
  } clock_t;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t [2:0] data;
    logic          val;
  } ph_data_t;
endpackage

// File: rtl/tdef_prm.sv
// rtl/tdef_prm.sv - numeric parameters shared by the SVPWM blocks
package tdef_prm;
  localparam int DATA_W      = 18;
  localparam int MAX_VOLTAGE = 24;
  localparam int GAIN_Q16    = 75674;
endpackage

// File: rtl/sv_minmax3.sv
// rtl/sv_minmax3.sv - combinational signed max/min of three samples
module sv_minmax3 #(
  parameter int DATA_W = tdef_prm::DATA_W
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [DATA_W-1:0] c_i,
  output logic signed [DATA_W-1:0] max_o,
  output logic signed [DATA_W-1:0] min_o
);
  logic signed [DATA_W-1:0] max_ab;
  logic signed [DATA_W-1:0] min_ab;

  assign max_ab = (a_i > b_i) ? a_i : b_i;
  assign min_ab = (a_i < b_i) ? a_i : b_i;
  assign max_o  = (max_ab > c_i) ? max_ab : c_i;
  assign min_o  = (min_ab < c_i) ? min_ab : c_i;
endmodule

// File: rtl/sv_mod.sv
// rtl/sv_mod.sv - 3-stage min-max zero-sequence injection SVPWM modulator
module sv_mod
  import tdef_pkg::*;
#(
  parameter int DATA_W   = tdef_prm::DATA_W,
  parameter int GAIN_Q16 = tdef_prm::GAIN_Q16
) (
  input  clock_t   clock,
  input  ph_data_t voltage,
  output ph_data_t out
);
  localparam int D_W = DATA_W + 1;
  localparam int P_W = DATA_W + 19;
  localparam logic        [17:0]    GAIN_L = 18'(GAIN_Q16);
  localparam logic signed [P_W-1:0] RND    = P_W'(32768);
  localparam logic signed [P_W-1:0] SAT_HI = P_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_LO = ~SAT_HI;

  logic clk;
  logic rstn;
  logic unused_ce;
  assign clk       = clock.clk;
  assign rstn      = clock.rstn;
  assign unused_ce = clock.ce;

  logic signed [DATA_W-1:0] vin [3];
  logic signed [DATA_W-1:0] max_d;
  logic signed [DATA_W-1:0] min_d;
  assign vin[0] = voltage.data[0];
  assign vin[1] = voltage.data[1];
  assign vin[2] = voltage.data[2];

  sv_minmax3 #(.DATA_W(DATA_W)) u_minmax (
    .a_i  (vin[0]),
    .b_i  (vin[1]),
    .c_i  (vin[2]),
    .max_o(max_d),
    .min_o(min_d)
  );

  logic                     vld1_q;
  logic signed [DATA_W-1:0] v1_q [3];
  logic signed [DATA_W-1:0] max1_q;
  logic signed [DATA_W-1:0] min1_q;
  logic                     vld2_q;
  logic signed [D_W-1:0]    diff2_q [3];
  logic                     val_q;
  logic signed [DATA_W-1:0] res_q [3];

  logic signed [D_W-1:0]    sum_d;
  logic signed [D_W-1:0]    off_d;
  logic signed [D_W-1:0]    diff_d [3];
  logic signed [P_W-1:0]    prod_d [3];
  logic signed [P_W-1:0]    rnd_d [3];
  logic signed [DATA_W-1:0] sat_d [3];

  // Offset uses floor division so it matches an arithmetic shift of the sum.
  always_comb begin
    sum_d = {max1_q[DATA_W-1], max1_q} + {min1_q[DATA_W-1], min1_q};
    off_d = sum_d >>> 1;
    for (int i = 0; i < 3; i++) begin
      diff_d[i] = {v1_q[i][DATA_W-1], v1_q[i]} - off_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      prod_d[i] = $signed({{18{diff2_q[i][D_W-1]}}, diff2_q[i]}) * $signed({1'b0, GAIN_L});
      rnd_d[i]  = (prod_d[i] + RND) >>> 16;
      if (rnd_d[i] > SAT_HI) begin
        sat_d[i] = SAT_HI[DATA_W-1:0];
      end else if (rnd_d[i] < SAT_LO) begin
        sat_d[i] = SAT_LO[DATA_W-1:0];
      end else begin
        sat_d[i] = rnd_d[i][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      val_q  <= 1'b0;
      max1_q <= '0;
      min1_q <= '0;
      for (int i = 0; i < 3; i++) begin
        v1_q[i]    <= '0;
        diff2_q[i] <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      vld1_q <= voltage.val;
      vld2_q <= vld1_q;
      val_q  <= vld2_q;
      if (voltage.val) begin
        v1_q   <= vin;
        max1_q <= max_d;
        min1_q <= min_d;
      end
      if (vld1_q) begin
        diff2_q <= diff_d;
      end
      if (vld2_q) begin
        res_q <= sat_d;
      end
    end
  end

  assign out = {res_q[2], res_q[1], res_q[0], val_q};
endmodule

// File: tb/tb_sv_mod.sv
// tb/tb_sv_mod.sv - directed vector and stream bench for sv_mod
module tb_sv_mod;
  import tdef_pkg::*;

  localparam longint K = 75674;

  logic     clk = 1'b0;
  logic     rstn = 1'b0;
  clock_t   clock;
  ph_data_t voltage;
  ph_data_t out;

  assign clock = {clk, rstn, 1'b0};

  sv_mod dut (
    .clock  (clock),
    .voltage(voltage),
    .out    (out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int v0, v1, v2;
    int e0, e1, e2;
  } vec_t;

  typedef struct {
    int  e0, e1, e2;
    int  due;
    bit  sine;
    real tgt;
  } exp_t;

  vec_t tbl [10];
  exp_t exp_q [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last0 = 0, last1 = 0, last2 = 0;

  function automatic int model_ch(longint v, longint off);
    longint p;
    longint r;
    p = (v - off) * K;
    r = (p + 32768) >>> 16;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return int'(r);
  endfunction

  function automatic longint model_off(longint a, longint b, longint c);
    longint mx;
    longint mn;
    mx = (a > b) ? a : b;
    mx = (mx > c) ? mx : c;
    mn = (a < b) ? a : b;
    mn = (mn < c) ? mn : c;
    return (mx + mn) >>> 1;
  endfunction

  task automatic check_cycle();
    int   o0, o1, o2;
    exp_t e;
    real  s;
    o0 = $signed(out.data[0]);
    o1 = $signed(out.data[1]);
    o2 = $signed(out.data[2]);
    n_chk++;
    if (out.val) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_val: got val=1 data (%0d,%0d,%0d), required no strobe at cycle %0d", o0, o1, o2, cyc);
      end else begin
        e = exp_q.pop_front();
        if (o0 != e.e0 || o1 != e.e1 || o2 != e.e2 || cyc != e.due) begin
          n_fail++;
          $display("FAIL result: got (%0d,%0d,%0d) at cycle %0d, required (%0d,%0d,%0d) at cycle %0d",
                   o0, o1, o2, cyc, e.e0, e.e1, e.e2, e.due);
        end
        if (e.sine) begin
          n_chk++;
          s = real'(o0 + o1 + o2);
          if (s - e.tgt > 2.0 || e.tgt - s > 2.0) begin
            n_fail++;
            $display("FAIL sine_sum: got %0d, required %f +/-2", o0 + o1 + o2, e.tgt);
          end
        end
        last0 = e.e0; last1 = e.e1; last2 = e.e2;
      end
    end else if (o0 != last0 || o1 != last1 || o2 != last2) begin
      n_fail++;
      $display("FAIL hold: got (%0d,%0d,%0d), required (%0d,%0d,%0d) at cycle %0d",
               o0, o1, o2, last0, last1, last2, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Idle cycles drive random data so ignored inputs are exercised.
  task automatic step(input bit val, input int a, input int b, input int c);
    tick();
    voltage.val = val;
    if (val) begin
      voltage.data[0] = sample_t'(a);
      voltage.data[1] = sample_t'(b);
      voltage.data[2] = sample_t'(c);
    end else begin
      voltage.data[0] = sample_t'($urandom);
      voltage.data[1] = sample_t'($urandom);
      voltage.data[2] = sample_t'($urandom);
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic push_exp(input int e0, input int e1, input int e2, input bit sine, input real tgt);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.e2 = e2;
    e.due = cyc + 4;
    e.sine = sine;
    e.tgt = tgt;
    exp_q.push_back(e);
  endtask

  task automatic send_model(input int a, input int b, input int c, input bit sine);
    longint off;
    real    tgt;
    off = model_off(a, b, c);
    tgt = real'(K) * real'(longint'(a) + b + c - 3 * off) / 65536.0;
    push_exp(model_ch(a, off), model_ch(b, off), model_ch(c, off), sine, tgt);
    step(1'b1, a, b, c);
  endtask

  initial begin
    real th;
    int  a, b, c;

    tbl[0] = '{1000, -500, -500, 866, -866, -866};
    tbl[1] = '{5000, 5000, 5000, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0};
    tbl[3] = '{131071, -131072, 0, 131071, -131072, 1};
    tbl[4] = '{-1000, 500, 500, -866, 866, 866};
    tbl[5] = '{100, 0, -100, 115, 0, -115};
    tbl[6] = '{3, 0, 0, 2, -1, -1};
    tbl[7] = '{-1, 0, 0, 0, 1, 1};
    tbl[8] = '{-70000, -70000, -70000, 0, 0, 0};
    tbl[9] = '{0, -131072, 131071, 1, -131072, 131071};

    voltage = '0;
    voltage.data[0] = sample_t'(123);
    voltage.val = 1'b1;
    rstn = 1'b0;
    repeat (3) tick();
    voltage.val = 1'b0;
    @(negedge clk);
    check_cycle();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check_cycle();

    // Push is made before step, so due is step cycle + 3.
    for (int i = 0; i < 10; i++) begin
      push_exp(tbl[i].e0, tbl[i].e1, tbl[i].e2, 1'b0, 0.0);
      step(1'b1, tbl[i].v0, tbl[i].v1, tbl[i].v2);
      repeat (4) step(1'b0, 0, 0, 0);
    end

    for (int i = 0; i < 10; i++) begin
      send_model(i * 12345 - 50000, 30000 - i * 7777, i * i * 1000 - 20000, 1'b0);
    end
    repeat (5) step(1'b0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      th = 6.283185307 * i / 12.0 + 0.3;
      a = $rtoi(100000.0 * $sin(th));
      b = $rtoi(100000.0 * $sin(th - 2.094395102));
      c = $rtoi(100000.0 * $sin(th + 2.094395102));
      send_model(a, b, c, 1'b1);
    end
    repeat (5) step(1'b0, 0, 0, 0);

    // Reset while a sample sits in stage 2; it must never emerge.
    push_exp(0, 0, 0, 1'b0, 0.0);
    step(1'b1, 1000, -500, -500);
    void'(exp_q.pop_back());
    step(1'b0, 0, 0, 0);
    tick();
    voltage.val = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    last0 = 0; last1 = 0; last2 = 0;
    n_chk++;
    if (out.val !== 1'b0 || out.data !== '0) begin
      n_fail++;
      $display("FAIL reset_flush: got val=%0b data=%h, required val=0 data=0", out.val, out.data);
    end
    repeat (5) step(1'b0, 0, 0, 0);

    push_exp(tbl[0].e0, tbl[0].e1, tbl[0].e2, 1'b0, 0.0);
    step(1'b1, tbl[0].v0, tbl[0].v1, tbl[0].v2);
    repeat (5) step(1'b0, 0, 0, 0);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_out: got %0d results outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
